ps2_rx_fifo: RTL

PS/2 device-to-host receiver with a scan-code FIFO, placed between the board's PS/2 clock/data pins and the CPU's keyboard port. It synchronizes both lines and frames 11-bit PS/2 packets (start, 8 data LSB-first, odd parity, stop). Valid bytes are buffered in a first-word-fall-through FIFO. When the FIFO is full it requests host inhibit, so the top level can hold the PS/2 clock low.

---
 rtl/ps2_pkg.sv | 22 ++
 rtl/ps2_sync_fifo.sv | 79 +++++++
 rtl/ps2_rx_fifo.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive path.
package ps2_pkg;

  // Start + 8 data + parity + stop.
  localparam int unsigned PS2_FRAME_BITS = 11;
  localparam int unsigned PS2_DATA_BITS  = PS2_FRAME_BITS - 3;

  typedef logic [PS2_DATA_BITS-1:0] ps2_byte_t;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_t;

  // Odd parity holds when the data bits and the parity bit XOR to 1.
  function automatic logic ps2_odd_ok(input ps2_byte_t b, input logic p);
    return ^{b, p};
  endfunction

endpackage

// File: rtl/ps2_sync_fifo.sv
// First-word-fall-through FIFO: head entry is always on rdata while valid.
// Push while full is dropped (overflow pulse) unless a pop happens in the same cycle.
module ps2_sync_fifo
  import ps2_pkg::*;
#(
  parameter int unsigned WIDTH = $bits(ps2_byte_t),
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             valid,
  output logic             full,
  output logic             overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr_n;
  logic [PW-1:0]    rd_ptr_n;
  logic             pop_c;
  logic             push_c;
  logic             full_n;
  logic             empty_n;
  logic             ovf_n;
  logic [WIDTH-1:0] head_n;

  // Next pointers, flags and head word after this cycle's push/pop.
  always_comb begin
    pop_c    = pop & valid;
    push_c   = push & (~full | pop_c);
    rd_ptr_n = rd_ptr + PW'(pop_c);
    wr_ptr_n = wr_ptr + PW'(push_c);
    empty_n  = (wr_ptr_n == rd_ptr_n);
    full_n   = (wr_ptr_n[AW] != rd_ptr_n[AW]) &&
               (wr_ptr_n[AW-1:0] == rd_ptr_n[AW-1:0]);
    ovf_n    = push & full & ~pop_c;
    // The new head may be the word being written right now (empty or last entry).
    if (push_c && (rd_ptr_n[AW-1:0] == wr_ptr[AW-1:0])) begin
      head_n = wdata;
    end else begin
      head_n = mem[rd_ptr_n[AW-1:0]];
    end
  end

  // Storage array; no reset needed on data.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wr_ptr[AW-1:0]] <= wdata;
    end
  end

  // Pointers and registered status/head outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rdata    <= '0;
      valid    <= 1'b0;
      full     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr_n;
      rd_ptr   <= rd_ptr_n;
      rdata    <= head_n;
      valid    <= ~empty_n;
      full     <= full_n;
      overflow <= ovf_n;
    end
  end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver feeding a scan-code FIFO.
// Optional build macro PS2_PARITY_CHECK_EN: reject frames with bad odd parity.
// Without it the parity bit is clocked past but not checked.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 5000,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      ps2Clk,
  input  logic      ps2Data,
  input  logic      rdEn,
  output ps2_byte_t rdData,
  output logic      rdValid,
  output logic      inhibitReq,
  output logic      frameErr,
  output logic      overflow
);

  localparam int unsigned TW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned BCW = $clog2(PS2_DATA_BITS);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   clk_d;
  logic                   clk_s;
  logic                   data_s;
  logic                   fall_c;

  ps2_state_t             state;
  ps2_state_t             state_n;
  logic [BCW-1:0]         bit_cnt;
  logic [BCW-1:0]         bit_cnt_n;
  ps2_byte_t              shreg;
  ps2_byte_t              shreg_n;
  logic [TW-1:0]          tcnt;
  logic                   tout_c;
  logic                   frame_ok_c;
  logic                   push_c;
  logic                   err_c;

  assign clk_s  = clk_sync[SYNC_STAGES-1];
  assign data_s = data_sync[SYNC_STAGES-1];
  assign fall_c = clk_d & ~clk_s;

  // Pin synchronizers plus one delay stage for falling-edge detect; idle bus is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_d     <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2Clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2Data};
      clk_d     <= clk_s;
    end
  end

  // Inactivity counter inside a frame; restarts on every sampled clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt <= '0;
    end else if ((state == IDLE) || fall_c) begin
      tcnt <= '0;
    end else begin
      tcnt <= tcnt + TW'(1);
    end
  end

  assign tout_c = (state != IDLE) && !fall_c && (tcnt == TW'(TIMEOUT_CYCLES - 1));

`ifdef PS2_PARITY_CHECK_EN
  logic par_bit;
  logic par_bit_n;

  // Parity bit captured in PARITY, checked at STOP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_bit <= 1'b0;
    end else begin
      par_bit <= par_bit_n;
    end
  end

  assign frame_ok_c = data_s & ps2_odd_ok(shreg, par_bit);
`else
  assign frame_ok_c = data_s;
`endif

  // Frame FSM state and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      shreg    <= '0;
      frameErr <= 1'b0;
    end else begin
      state    <= state_n;
      bit_cnt  <= bit_cnt_n;
      shreg    <= shreg_n;
      frameErr <= err_c;
    end
  end

  // Next-state logic; bits are taken only on the synchronized falling edge.
  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    push_c    = 1'b0;
    err_c     = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
    par_bit_n = par_bit;
`endif
    if (tout_c) begin
      state_n = IDLE;
      shreg_n = '0;
      err_c   = 1'b1;
    end else if (fall_c) begin
      unique case (state)
        IDLE: begin
          if (!data_s) begin
            state_n   = DATA;
            bit_cnt_n = '0;
          end
        end
        DATA: begin
          shreg_n   = {data_s, shreg[PS2_DATA_BITS-1:1]};
          bit_cnt_n = bit_cnt + BCW'(1);
          if (bit_cnt == BCW'(PS2_DATA_BITS - 1)) begin
            state_n = PARITY;
          end
        end
        PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
          par_bit_n = data_s;
`endif
          state_n = STOP;
        end
        STOP: begin
          state_n = IDLE;
          if (frame_ok_c) begin
            push_c = 1'b1;
          end else begin
            err_c = 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Scan-code buffer; full doubles as the host-inhibit request.
  ps2_sync_fifo #(
    .WIDTH (PS2_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push_c),
    .wdata    (shreg),
    .pop      (rdEn),
    .rdata    (rdData),
    .valid    (rdValid),
    .full     (inhibitReq),
    .overflow (overflow)
  );

endmodule
